// File: rtl/tenkey_sender.sv
// tenkey_sender: plays a 4-digit BCD code onto a one-hot key bus as press/gap events,
// optionally followed by a one-cycle close pulse.
module tenkey_sender #(
    parameter int PRESS_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic        ck,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] code,
    input  logic        with_close,
    input  logic        abort,
    output logic [9:0]  tenkey,
    output logic        close,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, PRESS, GAP, CLOSE, DONE} state_t;
    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] code_q, code_n;
    logic        wc_q, wc_n, err_n;
    logic [9:0]  tenkey_n;
    logic        close_n, busy_n, done_n;
    logic        valid;
    assign valid = code[15:12] <= 4'd9 && code[11:8] <= 4'd9 && code[7:4] <= 4'd9 && code[3:0] <= 4'd9;
    // outputs are registered copies of what the next state implies, so they align with state
    always_ff @(posedge ck) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            code_q <= '0;
            wc_q   <= 1'b0;
            tenkey <= '0;
            close  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            code_q <= code_n;
            wc_q   <= wc_n;
            tenkey <= tenkey_n;
            close  <= close_n;
            busy   <= busy_n;
            done   <= done_n;
            err    <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        code_n  = code_q;
        wc_n    = wc_q;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (valid) begin
                        state_n = PRESS;
                        idx_n   = 2'd3;
                        cnt_n   = '0;
                        code_n  = code;
                        wc_n    = with_close;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            PRESS: begin
                if (abort) state_n = IDLE;
                else if (cnt == 8'(PRESS_CYC - 1)) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else cnt_n = cnt + 8'd1;
            end
            GAP: begin
                if (abort) state_n = IDLE;
                else if (cnt == 8'(GAP_CYC - 1)) begin
                    cnt_n = '0;
                    if (idx != 2'd0) begin
                        state_n = PRESS;
                        idx_n   = idx - 2'd1;
                    end else state_n = wc_q ? CLOSE : DONE;
                end else cnt_n = cnt + 8'd1;
            end
            CLOSE: state_n = abort ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        tenkey_n = (state_n == PRESS) ? 10'd1 << code_n[{idx_n, 2'b00} +: 4] : 10'd0;
        close_n  = state_n == CLOSE;
        busy_n   = state_n == PRESS || state_n == GAP || state_n == CLOSE;
        done_n   = state_n == DONE;
    end
endmodule

// File: tb/tb_tenkey_sender.sv
// tb_tenkey_sender: schedule-based model of the key sequence checked every cycle,
// plus literal checkpoints from the directed scenarios.
module tb_tenkey_sender;
    localparam int P = 4;
    localparam int G = 4;
    localparam int BZ = 2;
    localparam int DN = 1;
    logic        ck = 1'b0;
    logic        reset, start, with_close, abort;
    logic [15:0] code;
    logic [9:0]  tenkey;
    logic        close, busy, done, err;
    logic [13:0] cur = '0;
    logic [13:0] q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          c = 0;
    tenkey_sender #(.PRESS_CYC(P), .GAP_CYC(G)) dut (
        .ck(ck), .reset(reset), .start(start), .code(code), .with_close(with_close),
        .abort(abort), .tenkey(tenkey), .close(close), .busy(busy), .done(done), .err(err)
    );
    always #5 ck = ~ck;
    function automatic logic [13:0] pk(input logic [9:0] tk, input logic cl, bz, dn, er);
        return {tk, cl, bz, dn, er};
    endfunction
    // expected outputs for the coming cycles are queued when a sequence is accepted
    always @(posedge ck) begin
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) if (code[i*4 +: 4] > 4'd9) ok = 1'b0;
        if (reset) begin
            q.delete();
            cur = '0;
        end else if (cur[BZ] && abort) begin
            q.delete();
            cur = '0;
        end else if (!cur[BZ] && !cur[DN] && start && !abort) begin
            if (ok) begin
                for (int i = 3; i >= 0; i--) begin
                    repeat (P) q.push_back(pk(10'd1 << code[i*4 +: 4], 0, 1, 0, 0));
                    repeat (G) q.push_back(pk(10'd0, 0, 1, 0, 0));
                end
                if (with_close) q.push_back(pk(10'd0, 1, 1, 0, 0));
                q.push_back(pk(10'd0, 0, 0, 1, 0));
                cur = q.pop_front();
            end else cur = pk(10'd0, 0, 0, 0, 1);
        end else cur = (q.size() > 0) ? q.pop_front() : '0;
        #1;
        n_cmp++;
        if ({tenkey, close, busy, done, err} !== cur) begin
            n_bad++;
            $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, {tenkey, close, busy, done, err}, cur);
        end
    end
    task automatic lit(input string nm, input logic [13:0] e);
        n_cmp++;
        if ({tenkey, close, busy, done, err} !== e || cur !== e) begin
            n_bad++;
            $display("FAIL %s: dut=%h model=%h expected=%h", nm, {tenkey, close, busy, done, err}, cur, e);
        end
    endtask
    task automatic to(input int k);
        while (c < k) begin
            @(negedge ck);
            c++;
        end
    endtask
    task automatic go(input logic [15:0] cd, input logic wc);
        start = 1'b1;
        code = cd;
        with_close = wc;
        @(negedge ck);
        c = 1;
        start = 1'b0;
    endtask
    initial begin
        reset = 1'b1; start = 1'b0; code = '0; with_close = 1'b0; abort = 1'b0;
        repeat (3) @(negedge ck);
        lit("reset_state", '0);
        reset = 1'b0;
        @(negedge ck);
        go(16'h1234, 1'b0);
        lit("t1_c1", pk(10'h002, 0, 1, 0, 0));
        to(4);  lit("t1_c4", pk(10'h002, 0, 1, 0, 0));
        to(5);  lit("t1_c5", pk(10'h000, 0, 1, 0, 0));
        to(9);  lit("t1_c9", pk(10'h004, 0, 1, 0, 0));
        to(17); lit("t1_c17", pk(10'h008, 0, 1, 0, 0));
        to(25); lit("t1_c25", pk(10'h010, 0, 1, 0, 0));
        to(32); lit("t1_c32", pk(10'h000, 0, 1, 0, 0));
        to(33); lit("t1_done", pk(10'h000, 0, 0, 1, 0));
        to(34); lit("t1_idle", '0);
        go(16'h9990, 1'b1);
        lit("t2_c1", pk(10'h200, 0, 1, 0, 0));
        to(17); lit("t2_c17", pk(10'h200, 0, 1, 0, 0));
        to(25); lit("t2_c25", pk(10'h001, 0, 1, 0, 0));
        to(33); lit("t2_close", pk(10'h000, 1, 1, 0, 0));
        to(34); lit("t2_done", pk(10'h000, 0, 0, 1, 0));
        to(36);
        go(16'h12A4, 1'b0);
        lit("t3_err", pk(10'h000, 0, 0, 0, 1));
        to(2);  lit("t3_after", '0);
        abort = 1'b1;
        go(16'h12A4, 1'b0);
        abort = 1'b0;
        lit("idle_abort_no_err", '0);
        to(3);
        go(16'h1234, 1'b0);
        to(10); start = 1'b1; code = 16'h5678;
        to(11); start = 1'b0;
        to(17); lit("t4_c17", pk(10'h008, 0, 1, 0, 0));
        to(25); lit("t4_c25", pk(10'h010, 0, 1, 0, 0));
        to(33); lit("t4_done", pk(10'h000, 0, 0, 1, 0));
        to(35);
        go(16'h1234, 1'b0);
        to(6);  lit("t5_gap", pk(10'h000, 0, 1, 0, 0)); abort = 1'b1;
        to(7);  lit("t5_aborted", '0); abort = 1'b0;
        to(8);  lit("t5_no_done", '0); start = 1'b1; code = 16'h1234;
        to(9);  start = 1'b0; lit("t5_restart", pk(10'h002, 0, 1, 0, 0));
        to(41); lit("t5_done", pk(10'h000, 0, 0, 1, 0));
        to(43);
        go(16'h5678, 1'b1);
        to(3);  lit("t6_press", pk(10'h020, 0, 1, 0, 0)); reset = 1'b1;
        to(4);  lit("t6_reset", '0); reset = 1'b0;
        to(5);
        go(16'h0987, 1'b0);
        lit("t6_c1", pk(10'h001, 0, 1, 0, 0));
        to(9);  lit("t6_c9", pk(10'h200, 0, 1, 0, 0));
        to(33); lit("t6_done", pk(10'h000, 0, 0, 1, 0));
        to(36);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
